wfq_div_stage: RTL and testbench
================================

Name: wfq_div_stage

Overview:
- Front stage of the WFQ rank-calculation path. Sits directly upstream of the WFQ round/overflow engine and feeds its req_valid / req_class_id / req_div_quotient / req_div_remain inputs.
- For each packet it looks up the per-class weight in an internal table and divides packet length by that weight with an iterative restoring divider (one quotient bit per cycle).
- It emits a single-cycle result pulse whose spacing always satisfies the engine's 3-cycle request occupancy.

Parameters:
- CLASS_WIDTH, 5, class id width; table depth is 2**CLASS_WIDTH.
- WEIGHT_WIDTH, 16, weight, quotient and remainder width.
- PKT_WIDTH, 16, packet-length (dividend) width; also the number of divide iterations.
- DEFAULT_WEIGHT, 1, weight loaded into every table entry on reset.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  packet request valid.
- in_ready  out  1  stage can accept a request.
- in_class_id  in  CLASS_WIDTH  class of packet.
- in_pkt_len  in  PKT_WIDTH  packet length (bytes).
- cfg_wr_en  in  1  weight-table write strobe.
- cfg_class_id  in  CLASS_WIDTH  entry to write.
- cfg_weight  in  WEIGHT_WIDTH  new weight.
- out_valid  out  1  result pulse (drives engine req_valid).
- out_class_id  out  CLASS_WIDTH  class of result.
- out_quotient  out  WEIGHT_WIDTH  floor(len/weight), saturated.
- out_remain  out  WEIGHT_WIDTH  len mod weight.
- out_div_zero  out  1  weight was 0 for this result.

Behaviour:
- Clock is clk. Reset is rst: synchronous, active-high.
- Reset values: in_ready=1, out_valid=0, out_class_id=0, out_quotient=0, out_remain=0, out_div_zero=0, FSM=IDLE, all table entries=DEFAULT_WEIGHT.
- FSM states: IDLE, DIV, OUT.
- IDLE:
  - in_ready=1.
  - Accept when in_valid at an edge. On accept, capture class id, dividend=in_pkt_len, divisor=table[in_class_id], partial remainder=0, iteration counter=PKT_WIDTH-1, and go to DIV.
- DIV:
  - in_ready=0.
  - Each cycle: tmp={rem, dividend MSB} (WEIGHT_WIDTH+1 bits). If tmp>=divisor, rem=tmp-divisor and shift quotient bit 1 in; otherwise rem=tmp and shift 0 in. Dividend shifts left.
  - When counter==0, go to OUT; otherwise decrement the counter.
- OUT:
  - out_valid=1 for exactly this cycle. Output registers hold the result, then the FSM returns to IDLE.
  - out_* data holds its value until the next OUT.
- Latency: accept at edge T0; DIV occupies PKT_WIDTH cycles; out_valid is high in cycle T0+PKT_WIDTH+1; in_ready is high again in the following cycle.
- Throughput: one result per PKT_WIDTH+2 cycles. Pulses are never closer than 3 cycles; PKT_WIDTH must be >=2 (elaboration check).
- Divide by zero: if the captured divisor==0, out_quotient=all ones, out_remain=0, out_div_zero=1. The DIV iterations still run, so timing is unchanged.
- Saturation: if PKT_WIDTH>WEIGHT_WIDTH and the true quotient exceeds 2**WEIGHT_WIDTH-1, out_quotient=all ones and out_remain=the true remainder.
- Length 0 gives quotient 0, remainder 0.
- Table writes:
  - A table write takes effect at the edge where cfg_wr_en is sampled.
  - A write to the same class in the same cycle as an accept: the accepted request uses the OLD weight.
  - Writes during DIV/OUT never disturb the in-flight divisor.
- No backpressure from downstream. The downstream engine is guaranteed idle by the pulse spacing.
- Reset mid-operation: the in-flight division is aborted, no out_valid is produced, and the table returns to DEFAULT_WEIGHT.

Test Plan:
- After reset (all weights 1), class 0, len 1500 -> out_valid exactly 17 cycles after accept; quotient 1500, remain 0, div_zero 0; in_ready high the next cycle.
- cfg write class 3 weight 7, then class 3 len 100 -> quotient 14, remain 2. Then class 3 len 0 -> quotient 0, remain 0.
- cfg write class 5 weight 0, then class 5 len 64 -> quotient 0xFFFF, remain 0, div_zero 1, same latency.
- in_valid held high with 3 requests (class 1 len 40, class 2 len 41, class 1 len 1) at weight 8 -> accepts 18 cycles apart; out pulses 18 cycles apart with (5,0), (5,1), (0,1); out_valid never high 2 cycles in a row.
- cfg write class 4 weight 10 in the same cycle as accepting class 4 len 100 (old weight 1) -> quotient 100, remain 0. The next class 4 len 100 -> quotient 10, remain 0.
- rst asserted in the 8th DIV cycle (class 3 weight 7 loaded) -> no out_valid; in_ready=1 the cycle after reset. A subsequent class 3 len 100 -> quotient 100, remain 0 (weight back to 1).

Source files
------------

// File: rtl/wfq_div_stage.sv
// WFQ front stage: per-class weight lookup followed by a restoring divider
// (one quotient bit per cycle), emitting a single-cycle result pulse.
module wfq_div_stage #(
  parameter int CLASS_WIDTH    = 5,
  parameter int WEIGHT_WIDTH   = 16,
  parameter int PKT_WIDTH      = 16,
  parameter int DEFAULT_WEIGHT = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [CLASS_WIDTH-1:0]  in_class_id,
  input  logic [PKT_WIDTH-1:0]    in_pkt_len,
  input  logic                    cfg_wr_en,
  input  logic [CLASS_WIDTH-1:0]  cfg_class_id,
  input  logic [WEIGHT_WIDTH-1:0] cfg_weight,
  output logic                    out_valid,
  output logic [CLASS_WIDTH-1:0]  out_class_id,
  output logic [WEIGHT_WIDTH-1:0] out_quotient,
  output logic [WEIGHT_WIDTH-1:0] out_remain,
  output logic                    out_div_zero
);
  localparam int DEPTH = 2**CLASS_WIDTH;
  localparam int CNT_W = $clog2(PKT_WIDTH);
  localparam int QW    = (PKT_WIDTH > WEIGHT_WIDTH) ? PKT_WIDTH : WEIGHT_WIDTH;

  // Two iterations minimum keeps result pulses at least 3 cycles apart.
  if (PKT_WIDTH < 2) begin : g_pkt_width_chk
    $error("wfq_div_stage: PKT_WIDTH must be >= 2");
  end

  typedef enum logic [1:0] {IDLE, DIV, OUT} state_t;

  state_t                  r_state;
  logic [WEIGHT_WIDTH-1:0] r_weight [DEPTH];
  logic [CLASS_WIDTH-1:0]  r_cls;
  logic [PKT_WIDTH-1:0]    r_dividend;
  logic [WEIGHT_WIDTH-1:0] r_divisor;
  logic [WEIGHT_WIDTH-1:0] r_rem;
  logic [PKT_WIDTH-1:0]    r_quo;
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_in_ready;
  logic                    r_out_valid;
  logic [CLASS_WIDTH-1:0]  r_out_cls;
  logic [WEIGHT_WIDTH-1:0] r_out_quo;
  logic [WEIGHT_WIDTH-1:0] r_out_rem;
  logic                    r_out_dz;

  logic [WEIGHT_WIDTH:0]   w_tmp;
  logic [WEIGHT_WIDTH:0]   w_sub;
  logic                    w_ge;
  logic [WEIGHT_WIDTH-1:0] w_rem_nxt;
  logic [PKT_WIDTH-1:0]    w_quo_nxt;
  logic [QW-1:0]           w_quo_full;
  logic                    w_sat;

  // One restoring step; rem < divisor always fits WEIGHT_WIDTH bits.
  assign w_tmp      = {r_rem, r_dividend[PKT_WIDTH-1]};
  assign w_sub      = w_tmp - {1'b0, r_divisor};
  assign w_ge       = (w_tmp >= {1'b0, r_divisor});
  assign w_rem_nxt  = w_ge ? w_sub[WEIGHT_WIDTH-1:0] : w_tmp[WEIGHT_WIDTH-1:0];
  assign w_quo_nxt  = {r_quo[PKT_WIDTH-2:0], w_ge};
  assign w_quo_full = QW'(w_quo_nxt);
  assign w_sat      = |(w_quo_full >> WEIGHT_WIDTH);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_weight[i] <= WEIGHT_WIDTH'(DEFAULT_WEIGHT);
    end else if (cfg_wr_en) begin
      r_weight[cfg_class_id] <= cfg_weight;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cls       <= '0;
      r_dividend  <= '0;
      r_divisor   <= '0;
      r_rem       <= '0;
      r_quo       <= '0;
      r_cnt       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_cls   <= '0;
      r_out_quo   <= '0;
      r_out_rem   <= '0;
      r_out_dz    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            // Table read sees the pre-write weight on a same-cycle cfg write.
            r_cls      <= in_class_id;
            r_dividend <= in_pkt_len;
            r_divisor  <= r_weight[in_class_id];
            r_rem      <= '0;
            r_quo      <= '0;
            r_cnt      <= CNT_W'(PKT_WIDTH - 1);
            r_in_ready <= 1'b0;
            r_state    <= DIV;
          end
        end
        DIV: begin
          r_rem      <= w_rem_nxt;
          r_quo      <= w_quo_nxt;
          r_dividend <= {r_dividend[PKT_WIDTH-2:0], 1'b0};
          if (r_cnt == '0) begin
            r_out_valid <= 1'b1;
            r_out_cls   <= r_cls;
            if (r_divisor == '0) begin
              r_out_quo <= '1;
              r_out_rem <= '0;
              r_out_dz  <= 1'b1;
            end else begin
              r_out_quo <= w_sat ? '1 : w_quo_full[WEIGHT_WIDTH-1:0];
              r_out_rem <= w_rem_nxt;
              r_out_dz  <= 1'b0;
            end
            r_state <= OUT;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        OUT: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready     = r_in_ready;
  assign out_valid    = r_out_valid;
  assign out_class_id = r_out_cls;
  assign out_quotient = r_out_quo;
  assign out_remain   = r_out_rem;
  assign out_div_zero = r_out_dz;
endmodule

// File: tb/tb_wfq_div_stage.sv
// Directed bench for wfq_div_stage: table-driven single requests plus
// back-to-back, same-cycle cfg write and mid-division reset sequences.
module tb_wfq_div_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_class_id;
  logic [15:0] in_pkt_len;
  logic        cfg_wr_en;
  logic [4:0]  cfg_class_id;
  logic [15:0] cfg_weight;
  logic        out_valid;
  logic [4:0]  out_class_id;
  logic [15:0] out_quotient;
  logic [15:0] out_remain;
  logic        out_div_zero;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wfq_div_stage #(.CLASS_WIDTH(5), .WEIGHT_WIDTH(16), .PKT_WIDTH(16), .DEFAULT_WEIGHT(1)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_class_id(in_class_id), .in_pkt_len(in_pkt_len),
    .cfg_wr_en(cfg_wr_en), .cfg_class_id(cfg_class_id), .cfg_weight(cfg_weight),
    .out_valid(out_valid), .out_class_id(out_class_id), .out_quotient(out_quotient),
    .out_remain(out_remain), .out_div_zero(out_div_zero)
  );

  typedef struct {
    string       nm;
    int          mode;   // 0 none, 1 cfg write first, 2 cfg write with accept
    logic [4:0]  cls;
    logic [15:0] w;
    logic [15:0] len;
    logic [15:0] eq;
    logic [15:0] er;
    logic        dz;
  } vec_t;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cfg_write(input logic [4:0] cls, input logic [15:0] w);
    cfg_wr_en = 1'b1; cfg_class_id = cls; cfg_weight = w;
    @(posedge clk); #1;
    cfg_wr_en = 1'b0;
  endtask

  task automatic run_req(input string nm, input logic [4:0] cls, input logic [15:0] len,
                         input bit same_wr, input logic [15:0] same_w,
                         input logic [15:0] eq, input logic [15:0] er, input logic edz);
    int n = 0;
    int lat = 0;
    while (!in_ready && n < 40) begin @(posedge clk); #1; n++; end
    check({nm, "_ready"}, in_ready, 1);
    in_valid = 1'b1; in_class_id = cls; in_pkt_len = len;
    cfg_wr_en = same_wr; cfg_class_id = cls; cfg_weight = same_w;
    @(posedge clk); #1;
    in_valid = 1'b0; cfg_wr_en = 1'b0;
    for (int k = 1; k <= 40 && lat == 0; k++) begin
      @(negedge clk);
      if (out_valid) lat = k;
    end
    check({nm, "_lat"}, lat, 17);
    check({nm, "_cls"}, out_class_id, cls);
    check({nm, "_quo"}, out_quotient, eq);
    check({nm, "_rem"}, out_remain, er);
    check({nm, "_dz"}, out_div_zero, edz);
    @(negedge clk);
    check({nm, "_pulse1"}, out_valid, 0);
    check({nm, "_rdy_after"}, in_ready, 1);
    check({nm, "_hold"}, out_quotient, eq);
    @(posedge clk); #1;
  endtask

  initial begin
    vec_t vt[9];
    int acc_t[$];
    int out_t[$];
    logic [15:0] oq[$];
    logic [15:0] orr[$];
    int prev_out;
    int dbl;
    int seen;
    logic [4:0]  bc[3];
    logic [15:0] bl[3];
    int idx;
    bit acc;

    vt[0] = '{"w1_1500",  0, 5'd0, 16'd0,     16'd1500,  16'd1500,  16'd0,     1'b0};
    vt[1] = '{"w7_100",   1, 5'd3, 16'd7,     16'd100,   16'd14,    16'd2,     1'b0};
    vt[2] = '{"w7_len0",  0, 5'd3, 16'd0,     16'd0,     16'd0,     16'd0,     1'b0};
    vt[3] = '{"w0_64",    1, 5'd5, 16'd0,     16'd64,    16'hFFFF,  16'd0,     1'b1};
    vt[4] = '{"w1000",    1, 5'd6, 16'd1000,  16'd65535, 16'd65,    16'd535,   1'b0};
    vt[5] = '{"wmax",     1, 5'd7, 16'd65535, 16'd65534, 16'd0,     16'd65534, 1'b0};
    vt[6] = '{"w3",       1, 5'd8, 16'd3,     16'd65535, 16'd21845, 16'd0,     1'b0};
    vt[7] = '{"same_cyc", 2, 5'd4, 16'd10,    16'd100,   16'd100,   16'd0,     1'b0};
    vt[8] = '{"after_wr", 0, 5'd4, 16'd0,     16'd100,   16'd10,    16'd0,     1'b0};

    rst = 1'b1; in_valid = 1'b0; in_class_id = '0; in_pkt_len = '0;
    cfg_wr_en = 1'b0; cfg_class_id = '0; cfg_weight = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_ready", in_ready, 1);
    check("rst_valid", out_valid, 0);
    check("rst_cls", out_class_id, 0);
    check("rst_quo", out_quotient, 0);
    check("rst_rem", out_remain, 0);
    check("rst_dz", out_div_zero, 0);
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) begin
      if (vt[i].mode == 1) cfg_write(vt[i].cls, vt[i].w);
      run_req(vt[i].nm, vt[i].cls, vt[i].len, vt[i].mode == 2, vt[i].w,
              vt[i].eq, vt[i].er, vt[i].dz);
    end

    // in_valid held high across three requests at weight 8
    cfg_write(5'd1, 16'd8);
    cfg_write(5'd2, 16'd8);
    bc = '{5'd1, 5'd2, 5'd1};
    bl = '{16'd40, 16'd41, 16'd1};
    idx = 0; prev_out = -10; dbl = 0;
    in_valid = 1'b1; in_class_id = bc[0]; in_pkt_len = bl[0];
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (out_valid) begin
        if (prev_out == c - 1) dbl++;
        prev_out = c;
        out_t.push_back(c); oq.push_back(out_quotient); orr.push_back(out_remain);
      end
      acc = in_valid && in_ready;
      if (acc) acc_t.push_back(c);
      @(posedge clk); #1;
      if (acc) begin
        idx++;
        if (idx < 3) begin in_class_id = bc[idx]; in_pkt_len = bl[idx]; end
        else in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    check("b2b_n_acc", acc_t.size(), 3);
    check("b2b_n_out", out_t.size(), 3);
    check("b2b_no_double", dbl, 0);
    if (acc_t.size() == 3 && out_t.size() == 3) begin
      check("b2b_acc_gap1", acc_t[1] - acc_t[0], 18);
      check("b2b_acc_gap2", acc_t[2] - acc_t[1], 18);
      check("b2b_out_gap1", out_t[1] - out_t[0], 18);
      check("b2b_out_gap2", out_t[2] - out_t[1], 18);
      check("b2b_lat0", out_t[0] - acc_t[0], 17);
      check("b2b_q0", oq[0], 5);  check("b2b_r0", orr[0], 0);
      check("b2b_q1", oq[1], 5);  check("b2b_r1", orr[1], 1);
      check("b2b_q2", oq[2], 0);  check("b2b_r2", orr[2], 1);
    end

    // reset during the 8th DIV cycle
    cfg_write(5'd3, 16'd7);
    check("mid_ready", in_ready, 1);
    in_valid = 1'b1; in_class_id = 5'd3; in_pkt_len = 16'd100;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1 rst = 1'b1;
    check("mid_busy", in_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("mid_rdy_after_rst", in_ready, 1);
    check("mid_quo_cleared", out_quotient, 0);
    seen = 0;
    for (int c = 0; c < 25; c++) begin
      if (out_valid) seen++;
      @(negedge clk);
    end
    check("mid_no_valid", seen, 0);
    @(posedge clk); #1;
    run_req("post_rst", 5'd3, 16'd100, 1'b0, 16'd0, 16'd100, 16'd0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
